// File: rtl/fetch_pc_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_pc_unit_pkg : shared CPU constants, opcode field, fetch FSM states  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
package fetch_pc_unit_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int OPC_MSB    = 15;
  localparam int OPC_LSB    = 12;
  localparam int OPC_W      = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] CPU_HALT_OP = 4'hF;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_out_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_out_reg : valid/ready pipeline output register, holds on stall      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module fetch_out_reg
  import fetch_pc_unit_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              out_ready,
  output logic              slot_free,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc
);

  logic              r_valid;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_pc;

  // Flush wins over everything, including a stalled consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_instr <= in_instr;
      r_pc    <= in_pc;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign slot_free = ~r_valid | out_ready;
  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_pc_unit : PC, sync-read imem fetch, branch redirect and HALT stop   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int               DATA_W   = CPU_DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [OPC_W-1:0]  HALT_OP  = CPU_HALT_OP
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc,
  output logic              halted
);

  fetch_state_e      r_state;
  logic [DATA_W-1:0] r_pc;
  logic              r_pend;
  logic [DATA_W-1:0] r_pend_pc;

  fetch_state_e      w_state_nxt;
  logic [DATA_W-1:0] w_pc_nxt;
  logic              w_pend_nxt;
  logic [DATA_W-1:0] w_pend_pc_nxt;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_halt_hit;
  logic              w_fetch_seq;
  logic              w_en;
  logic [DATA_W-1:0] w_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_pc <= w_pend_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pend_nxt    = r_pend;
    w_pend_pc_nxt = r_pend_pc;

    w_accept    = r_pend & w_slot_free & ~branch_taken;
    w_halt_hit  = w_accept & (imem_rdata[OPC_MSB:OPC_LSB] == HALT_OP);
    // A HALT word being accepted must not launch the fetch behind it.
    w_fetch_seq = (r_state == ST_RUN) & (~r_pend | w_accept) & ~w_halt_hit;
    w_en        = branch_taken | w_fetch_seq;
    w_addr      = branch_taken ? branch_target : r_pc;

    if (branch_taken) begin
      w_pc_nxt      = branch_target + DATA_W'(1);
      w_pend_nxt    = 1'b1;
      w_pend_pc_nxt = branch_target;
      w_state_nxt   = ST_RUN;
    end else begin
      if (w_fetch_seq) begin
        w_pc_nxt      = r_pc + DATA_W'(1);
        w_pend_nxt    = 1'b1;
        w_pend_pc_nxt = r_pc;
      end else if (w_accept) begin
        w_pend_nxt = 1'b0;
      end
      if (w_halt_hit) begin
        w_state_nxt = ST_HALT;
      end
    end
  end

  fetch_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (branch_taken),
    .load      (w_accept),
    .in_instr  (imem_rdata),
    .in_pc     (r_pend_pc),
    .out_ready (out_ready),
    .slot_free (w_slot_free),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc)
  );

  assign imem_addr = w_addr;
  assign imem_en   = w_en;
  assign halted    = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_pc_unit : vector table + scoreboard bench for fetch_pc_unit      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_fetch_pc_unit;

  typedef struct {
    logic        rdy;
    logic        br;
    logic [15:0] tgt;
    logic        ev;
    logic [15:0] epc;
    logic        een;
    logic [15:0] eaddr;
  } vec_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic [15:0] imem_rdata;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;

  logic [15:0] wr_addr;
  logic        wr_en;
  logic [15:0] wr_rdata;
  logic        wr_valid;
  logic [15:0] wr_instr;
  logic [15:0] wr_pc;
  logic        wr_halted;

  logic        halt_en;
  logic [15:0] halt_addr;

  int  n_cmp = 0;
  int  n_bad = 0;
  sb_t sb_q[$];
  vec_t tbl[16];

  fetch_pc_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_en       (imem_en),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted)
  );

  fetch_pc_unit #(
    .RESET_PC (16'hFFFE)
  ) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (wr_addr),
    .imem_en       (wr_en),
    .imem_rdata    (wr_rdata),
    .branch_taken  (1'b0),
    .branch_target (16'h0000),
    .out_valid     (wr_valid),
    .out_ready     (out_ready),
    .out_instr     (wr_instr),
    .out_pc        (wr_pc),
    .halted        (wr_halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'hF000;
    return a ^ 16'hA000;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
    if (wr_en)   wr_rdata   <= wr_addr ^ 16'hA000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] instr);
    sb_t e;
    e.pc    = pc;
    e.instr = instr;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    #3;
    chk(name, sb_q.size(), 0);
  endtask

  // Every handshake with outstanding expectations is checked in order.
  always @(negedge clk) begin
    sb_t e;
    #2;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_pc", out_pc, e.pc);
      chk("sb_instr", out_instr, e.instr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wpc;
    int          k;

    //          rdy   br    tgt       ev    epc       een   eaddr
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0001};
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0002};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 16'h0003};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0004};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h0005};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0006};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b0, 16'h0007};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b0, 16'h0007};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b0, 16'h0007};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h0007};
    tbl[11] = '{1'b0, 1'b1, 16'h0040, 1'b1, 16'h0006, 1'b1, 16'h0040};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0041};
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1, 16'h0042};
    tbl[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b1, 16'h0043};
    tbl[15] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 16'h0044};

    rst_n         = 1'b0;
    out_ready     = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    halt_en       = 1'b0;
    halt_addr     = 16'h0003;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_wrap_addr", wr_addr, 16'hFFFE);
    chk("rst_wrap_valid", wr_valid, 0);

    // Stream, backpressure and branch from a cycle-accurate vector table
    for (int i = 0; i <= 5; i++) push(16'(i), 16'(i) ^ 16'hA000);
    push(16'h0040, 16'hA040);
    push(16'h0041, 16'hA041);
    push(16'h0042, 16'hA042);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      out_ready     = tbl[i].rdy;
      branch_taken  = tbl[i].br;
      branch_target = tbl[i].tgt;
      #1;
      chk($sformatf("row%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("row%0d_en", i), imem_en, tbl[i].een);
      chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("row%0d_halted", i), halted, 0);
      if (tbl[i].ev) begin
        chk($sformatf("row%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("row%0d_instr", i), out_instr, tbl[i].epc ^ 16'hA000);
      end
      if (i <= 10) begin
        chk($sformatf("row%0d_wrap_valid", i), wr_valid, tbl[i].ev);
        if (tbl[i].ev) begin
          wpc = tbl[i].epc + 16'hFFFE;
          chk($sformatf("row%0d_wrap_pc", i), wr_pc, wpc);
          chk($sformatf("row%0d_wrap_instr", i), wr_instr, wpc ^ 16'hA000);
        end
      end
    end
    @(negedge clk);
    branch_taken = 1'b0;
    out_ready    = 1'b1;
    wait_drain("stream_sb_drain");

    // HALT word at 0003
    @(negedge clk);
    rst_n   = 1'b0;
    halt_en = 1'b1;
    sb_q.delete();
    push(16'h0000, 16'hA000);
    push(16'h0001, 16'hA001);
    push(16'h0002, 16'hA002);
    push(16'h0003, 16'hF000);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!(out_valid === 1'b1 && out_pc === 16'h0003) && k < 20);
    chk("halt_word_pc", out_pc, 16'h0003);
    chk("halt_word_instr", out_instr, 16'hF000);
    chk("halt_set", halted, 1);
    chk("halt_no_fetch", imem_en, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("halt_idle_en", imem_en, 0);
      chk("halt_idle_halted", halted, 1);
      chk("halt_drained", out_valid, 0);
    end
    wait_drain("halt_sb_drain");

    // Branch out of HALT
    push(16'h0010, 16'hA010);
    push(16'h0011, 16'hA011);
    @(negedge clk);
    branch_taken  = 1'b1;
    branch_target = 16'h0010;
    #1;
    chk("unhalt_en", imem_en, 1);
    chk("unhalt_addr", imem_addr, 16'h0010);
    @(negedge clk);
    branch_taken = 1'b0;
    #1;
    chk("unhalt_halted", halted, 0);
    chk("unhalt_bubble", out_valid, 0);
    @(negedge clk);
    #1;
    chk("unhalt_valid", out_valid, 1);
    chk("unhalt_pc", out_pc, 16'h0010);
    wait_drain("unhalt_sb_drain");

    // Redirect while the HALT word is pending flushes it
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    push(16'h0000, 16'hA000);
    push(16'h0001, 16'hA001);
    push(16'h0002, 16'hA002);
    push(16'h0020, 16'hA020);
    push(16'h0021, 16'hA021);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    branch_taken  = 1'b1;
    branch_target = 16'h0020;
    #1;
    chk("flush_addr", imem_addr, 16'h0020);
    @(negedge clk);
    branch_taken = 1'b0;
    #1;
    chk("flush_halted", halted, 0);
    chk("flush_bubble", out_valid, 0);
    @(negedge clk);
    #1;
    chk("flush_valid", out_valid, 1);
    chk("flush_pc", out_pc, 16'h0020);
    repeat (5) @(negedge clk);
    #1;
    chk("flush_still_run", halted, 0);
    wait_drain("flush_sb_drain");

    // Asynchronous reset between clock edges
    halt_en = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_halted", halted, 0);
    chk("async_addr", imem_addr, 16'h0000);
    chk("async_pc", out_pc, 16'h0000);
    chk("async_wrap_addr", wr_addr, 16'hFFFE);
    sb_q.delete();
    push(16'h0000, 16'hA000);
    push(16'h0001, 16'hA001);
    push(16'h0002, 16'hA002);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("restart_valid", out_valid, 1);
    chk("restart_pc", out_pc, 16'h0000);
    wait_drain("restart_sb_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch stage of the 16-bit CPU. It owns the program counter and drives a synchronous-read instruction memory. It delivers {pc, instruction} words to the decode stage through a valid/ready handshake. It handles branch redirects from execute and stops fetching on a HALT opcode.

Parameters:
DATA_W, 16, instruction and PC width.
RESET_PC, 16'h0000, first fetch address after reset.
HALT_OP, 4'hF, opcode in instr[15:12] that halts fetch.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
imem_addr  out  DATA_W  instruction memory address (combinational).
imem_en  out  1  memory samples imem_addr on this edge when 1; imem_rdata holds its value when 0.
imem_rdata  in  DATA_W  word for the last enabled address, valid the cycle after the enable.
branch_taken  in  1  redirect request from execute, single-cycle pulse.
branch_target  in  DATA_W  redirect address.
out_valid  out  1  out_instr/out_pc valid to decode.
out_ready  in  1  decode accepts this cycle.
out_instr  out  DATA_W  fetched instruction.
out_pc  out  DATA_W  address of out_instr.
halted  out  1  FSM is in HALT.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low (rst_n).
- Internal registers:
  - pc_r: next fetch address.
  - pend: imem_rdata is valid this cycle.
  - pend_pc: address that belongs to imem_rdata.
  - state: RUN or HALT.
  - output register: out_valid, out_instr, out_pc.
- Reset values (rst_n low, independent of clk): pc_r=RESET_PC, pend=0, pend_pc=0, state=RUN, out_valid=0, out_instr=0, out_pc=0, halted=0.
- Definitions:
  - redirect = branch_taken.
  - slot_free = !out_valid | out_ready.
  - accept = pend & slot_free & !redirect.
- imem_addr = redirect ? branch_target : pc_r.
- imem_en = redirect | (state==RUN & (!pend | accept)).
  - A pending word that cannot be accepted keeps the memory frozen, so there is no skid buffer.
- Redirect cycle (highest priority):
  - out_valid<=0 and pend<=0 apply first, even if out_ready=0.
  - Then the enabled fetch sets pc_r<=branch_target+1, pend<=1, pend_pc<=branch_target.
  - state<=RUN, even from HALT: the branch is older than the halt in program order.
- Non-redirect, imem_en=1 in RUN: pc_r<=pc_r+1 (mod 2^16, so FFFF wraps to 0000), pend<=1, pend_pc<=pc_r.
- Accept: out_instr<=imem_rdata, out_pc<=pend_pc, out_valid<=1.
  - If no new fetch is enabled in the same cycle, pend<=0.
  - If imem_rdata[15:12]==HALT_OP: state<=HALT and no further fetch is issued. The halt word itself is still delivered.
- out_valid & out_ready & !accept: out_valid<=0.
- HALT: imem_en=0 and halted=1 until a redirect or reset. The output register still drains normally.
- Latency:
  - Reset release to first out_valid: 2 cycles.
  - Steady state with out_ready=1: one instruction per cycle.
  - Redirect in cycle N: out_pc=branch_target with out_valid=1 in cycle N+2. This is a 1-bubble penalty.
- Backpressure: while out_valid & !out_ready, the outputs, pc_r and pend stay stable and imem_en=0. No instruction is dropped or duplicated.
- Simultaneous events:
  - Redirect and a HALT word pending in the same cycle: the HALT word is flushed and state stays RUN.
  - Redirect to the current pc_r is legal and refetches that address.
- Reset mid-operation: all registers clear immediately. The in-flight memory word is ignored because pend=0.

Decomposition:
- Shared cpu package: DATA_W, HALT_OP, the opcode field position [15:12], and the state encoding (RUN=1'b0, HALT=1'b1).
- One natural sub-module, fetch_out_reg: the valid/ready output register with hold-on-stall, reusable by later pipeline stages.
- The PC and FSM logic stay in the top module.

Test Plan:
1. Reset and stream: memory returns data = addr ^ 16'hA000, out_ready=1, release rst_n → out_valid in cycle 2 with out_pc=0000, out_instr=A000, then pc 0001, 0002, 0003 on consecutive cycles.
2. Backpressure: drop out_ready for 3 cycles while out_pc=0005 is shown → outputs held at 0005/A005, imem_en=0, imem_addr stable. After release: 0005 accepted, then 0006 next cycle, no gaps or repeats.
3. Branch: pulse branch_taken with target 0040 while pc 0007 is pending and out_ready=0 → out_valid=0 in the next cycle, out_pc=0040 valid two cycles after the pulse, then 0041.
4. Wrap: RESET_PC=FFFE → delivered pcs FFFE, FFFF, 0000, 0001.
5. Halt: word F000 at pc 0003 → pc 0003 delivered, halted=1, imem_en stays 0 for 10 cycles. Then branch_taken to 0010 → halted=0, out_pc=0010 two cycles later. Also: redirect in the same cycle the F000 word is pending → no halt.
6. Async reset: assert rst_n low mid-stream between clock edges → out_valid=0, halted=0, imem_addr=RESET_PC without waiting for a clock edge. Release → sequence restarts from RESET_PC.
